cpu_core_param: RTL and testbench

Parametrised multi-cycle CPU core, successor to the fixed 8-bit, four-register core. It integrates fetch/execute control, the register bank, the ALU and the output port in one block. Data width and register count are generic. Instruction memory sits outside the core behind a req/ack handshake, so wait-state memories are supported. It adds flags, conditional branching, two-word instructions, an input port and a halt state.

---
 rtl/cpu_core_param.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_core_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Multi-cycle CPU core: fetch/execute FSM, register bank, ALU, in/out ports; CPU_STEP_EN adds single-step gating.
// Latency: 2 cycles per single-word instruction, 3 for LDI/JMP/JZ, plus one cycle per fetch wait state.
// Backpressure: fetch req/addr held until imem_ack; with CPU_STEP_EN, FETCH waits for a step pulse.
module cpu_core_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int REG_SEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CPU_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              carry,
    output logic              zero,
    output logic              halted
);

    localparam int NREG = 1 << REG_SEL_W;
    localparam int IR_W = 4 + 2 * REG_SEL_W;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_IN  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JZ  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPER,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     pc;
    logic [IR_W-1:0]       ir;
    logic [DATA_W-1:0]     opnd;
    logic [DATA_W-1:0]     regs [NREG];

    logic [3:0]            op;
    logic [REG_SEL_W-1:0]  rd;
    logic [REG_SEL_W-1:0]  rs;
    logic [3:0]            fetch_op;
    logic                  go;
    logic                  fetch_fire;
    logic                  oper_fire;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     res;
    logic                  res_c;
    logic                  wr_en;
    logic                  upd_c;
    logic [ADDR_W-1:0]     jmp_tgt;

    assign op       = ir[IR_W-1 -: 4];
    assign rd       = ir[IR_W-5 -: REG_SEL_W];
    assign rs       = ir[REG_SEL_W-1:0];
    assign fetch_op = imem_rdata[DATA_W-1 -: 4];
    assign a        = regs[rd];
    assign b        = regs[rs];
    assign jmp_tgt  = ADDR_W'(opnd);

`ifdef CPU_STEP_EN
    // One pending step at most; a pulse arriving during an accepted fetch re-arms it.
    logic step_pend;
    assign go = step | step_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_pend <= 1'b0;
        end else if (fetch_fire) begin
            step_pend <= step_pend & step;
        end else if (step) begin
            step_pend <= 1'b1;
        end
    end
`else
    assign go = 1'b1;
`endif

    assign imem_addr  = pc;
    assign halted     = (state == S_HALT);
    assign fetch_fire = (state == S_FETCH) && imem_req && imem_ack;
    assign oper_fire  = (state == S_OPER) && imem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = go;
                if (go && imem_ack) begin
                    if (fetch_op == OP_LDI || fetch_op == OP_JMP || fetch_op == OP_JZ) begin
                        state_nxt = S_OPER;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_OPER: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // ALU: result, carry and which flags/registers the opcode touches.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        wr_en = 1'b0;
        upd_c = 1'b0;
        case (op)
            OP_ADD: begin
                {res_c, res} = {1'b0, a} + {1'b0, b};
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_SUB: begin
                {res_c, res} = {1'b0, a} - {1'b0, b};
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_AND: begin
                res   = a & b;
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_OR: begin
                res   = a | b;
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_XOR: begin
                res   = a ^ b;
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_NOT: begin
                res   = ~b;
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_SHL: begin
                res   = {b[DATA_W-2:0], 1'b0};
                res_c = b[DATA_W-1];
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_SHR: begin
                res   = {1'b0, b[DATA_W-1:1]};
                res_c = b[0];
                wr_en = 1'b1;
                upd_c = 1'b1;
            end
            OP_MOV: begin
                res   = b;
                wr_en = 1'b1;
            end
            OP_LDI: begin
                res   = opnd;
                wr_en = 1'b1;
            end
            OP_IN: begin
                res   = in_data;
                wr_en = 1'b1;
            end
            default: begin
                res = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            opnd      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (fetch_fire) begin
                ir <= imem_rdata[DATA_W-1 -: IR_W];
                pc <= pc + ADDR_W'(1);
            end
            if (oper_fire) begin
                opnd <= imem_rdata;
                pc   <= pc + ADDR_W'(1);
            end
            if (state == S_EXEC) begin
                if (wr_en) begin
                    regs[rd] <= res;
                    zero     <= (res == '0);
                end
                if (upd_c) begin
                    carry <= res_c;
                end
                if (op == OP_OUT) begin
                    out       <= a;
                    out_valid <= 1'b1;
                end
                if (op == OP_JMP || (op == OP_JZ && zero)) begin
                    pc <= jmp_tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: instruction-level reference model plus a fetch/out scoreboard with timing.
module tb_cpu_core_param;

    logic       clk;
    logic       rst;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] in_data;
    logic [7:0] out;
    logic       out_valid;
    logic       carry;
    logic       zero;
    logic       halted;

    cpu_core_param dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .in_data    (in_data),
        .out        (out),
        .out_valid  (out_valid),
        .carry      (carry),
        .zero       (zero),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int exp_addr[$];
    int exp_out[$];
    int exp_ocyc[$];
    int exp_c;
    int exp_z;
    int exp_hcyc;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    // Instruction-set model: runs the program in mem, recording fetch addresses, outputs and cycle stamps.
    task automatic model_run(input int inv);
        int pc, cyc, w, op, rd, rs, opnd, a, b, res;
        int r[4];
        bit wr;
        exp_addr.delete();
        exp_out.delete();
        exp_ocyc.delete();
        pc = 0; cyc = 0; exp_c = 0; exp_z = 0; exp_hcyc = -1;
        for (int i = 0; i < 4; i++) r[i] = 0;
        for (int s = 0; s < 500; s++) begin
            exp_addr.push_back(pc);
            w = int'(mem[pc]);
            pc = (pc + 1) % 256;
            cyc++;
            op = w / 16; rd = (w / 4) % 4; rs = w % 4; opnd = 0;
            if (op == 10 || op == 13 || op == 14) begin
                exp_addr.push_back(pc);
                opnd = int'(mem[pc]);
                pc = (pc + 1) % 256;
                cyc++;
            end
            cyc++;
            a = r[rd]; b = r[rs]; wr = 1; res = 0;
            case (op)
                1: begin res = (a + b) % 256; exp_c = (a + b > 255) ? 1 : 0; end
                2: begin res = (a - b + 256) % 256; exp_c = (a < b) ? 1 : 0; end
                3: begin res = a & b; exp_c = 0; end
                4: begin res = a | b; exp_c = 0; end
                5: begin res = a ^ b; exp_c = 0; end
                6: begin res = 255 - b; exp_c = 0; end
                7: begin res = (b * 2) % 256; exp_c = b / 128; end
                8: begin res = b / 2; exp_c = b % 2; end
                9: res = b;
                10: res = opnd;
                11: res = inv % 256;
                default: wr = 0;
            endcase
            if (wr) begin
                r[rd] = res;
                exp_z = (res == 0) ? 1 : 0;
            end
            if (op == 12) begin
                exp_out.push_back(a);
                exp_ocyc.push_back(cyc);
            end
            if (op == 13) pc = opnd;
            if (op == 14 && exp_z == 1) pc = opnd;
            if (op == 15) begin
                exp_hcyc = cyc;
                break;
            end
        end
    endtask

    task automatic gen_random();
        int starts[16];
        int jpos[16];
        int jidx[16];
        int nj, addr, op, n;
        clear_mem();
        n = 12; addr = 0; nj = 0;
        for (int i = 0; i < n; i++) begin
            starts[i] = addr;
            op = $urandom_range(15, 0);
            if (op == 15) op = 12;
            mem[addr] = 8'(op * 16 + $urandom_range(15, 0));
            addr++;
            if (op == 10) begin
                mem[addr] = 8'($urandom);
                addr++;
            end else if (op == 13 || op == 14) begin
                jpos[nj] = addr; jidx[nj] = i; nj++;
                addr++;
            end
        end
        starts[n] = addr;
        for (int k = 0; k < nj; k++) begin
            mem[jpos[k]] = 8'(starts[$urandom_range(n, jidx[k] + 1)]);
        end
    endtask

    // mode 0: ack always high; 1: random ack; 2: three wait states on the fetch at 0x04.
    task automatic run_prog(input int mode, input bit do_reset);
        int cycles, stalls, stall_left, ev, ec;
        bit done, prev_stall, ack;
        logic [7:0] prev_addr;
        in_data = 8'($urandom);
        model_run(int'(in_data));
        if (do_reset) begin
            rst = 1'b1;
            imem_ack = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 0);
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_halted", halted, 0);
        cycles = 0; stalls = 0; stall_left = 3; done = 0; prev_stall = 0; prev_addr = '0;
        while (!done && cycles < 2000) begin
            if (prev_stall) begin
                chk("hold_req", imem_req, 1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            case (mode)
                1: ack = ($urandom_range(3, 0) != 0);
                2: begin
                    ack = !(imem_req && imem_addr == 8'h04 && stall_left > 0);
                    if (!ack) stall_left--;
                end
                default: ack = 1'b1;
            endcase
            imem_ack = ack;
            imem_rdata = mem[imem_addr];
            prev_stall = imem_req && !ack;
            prev_addr = imem_addr;
            if (prev_stall) stalls++;
            if (imem_req && ack) begin
                ev = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hDEAD;
                chk("fetch_addr", imem_addr, ev);
            end
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                ev = (exp_out.size() > 0) ? exp_out.pop_front() : 32'hDEAD;
                ec = (exp_ocyc.size() > 0) ? exp_ocyc.pop_front() + stalls : 32'hDEAD;
                chk("out_value", out, ev);
                chk("out_cycle", cycles, ec);
            end
            if (halted) done = 1;
        end
        chk("halt_reached", done, 1);
        chk("halt_cycle", cycles, exp_hcyc + stalls);
        chk("halt_carry", carry, exp_c);
        chk("halt_zero", zero, exp_z);
        chk("outs_left", exp_out.size(), 0);
        chk("fetches_left", exp_addr.size(), 0);
        repeat (3) begin
            imem_ack = 1'($urandom);
            @(negedge clk);
        end
        chk("halt_req_low", imem_req, 0);
        chk("halt_stays", halted, 1);
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hF0; mem[2] = 8'hA4; mem[3] = 8'h20;
        mem[4] = 8'h11; mem[5] = 8'hC0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        in_data = '0;

        // Every register reads back zero straight out of reset.
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'hC4; mem[2] = 8'hC8; mem[3] = 8'hCC;
        run_prog(0, 1);

        load_prog_a();
        run_prog(0, 1);
        run_prog(2, 1);
        run_prog(1, 1);

        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h05; mem[2] = 8'hA4; mem[3] = 8'h05;
        mem[4] = 8'h21; mem[5] = 8'hE0; mem[6] = 8'h40;
        run_prog(0, 1);

        // JZ falls through first, then MOV sets Z, JMP to 0xFF, NOP wraps to 0x00, JZ taken.
        clear_mem();
        mem[0] = 8'hE0; mem[1] = 8'h10; mem[2] = 8'h90; mem[3] = 8'hD0;
        mem[4] = 8'hFF; mem[8'hFF] = 8'h00;
        run_prog(0, 1);
        run_prog(1, 1);

        // Reset lands while the LDI operand fetch is stalled.
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h55;
        rst = 1'b1;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = mem[0];
        @(negedge clk);
        imem_ack = 1'b0;
        chk("oper_addr", imem_addr, 1);
        chk("oper_req", imem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem[0] = 8'hC0; mem[1] = 8'hF0;
        run_prog(0, 0);

        for (int t = 0; t < 24; t++) begin
            gen_random();
            run_prog((t % 3 == 0) ? 0 : 1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
